// File: rtl/bcd2bin_arbiter_if.sv
// Client-side request/result signals and converter-side signals of bcd2bin_arbiter.
// The arbiter takes the slave view; clients and the converter sit on the master view.
interface bcd2bin_arbiter_if;
  logic       req_a;
  logic       req_b;
  logic [3:0] bcd1_a;
  logic [3:0] bcd0_a;
  logic [3:0] bcd1_b;
  logic [3:0] bcd0_b;
  logic       ack_a;
  logic       ack_b;
  logic       done_a;
  logic       done_b;
  logic       err_a;
  logic       err_b;
  logic [6:0] bin_out;
  logic       busy;
  logic       conv_start;
  logic [3:0] conv_bcd1;
  logic [3:0] conv_bcd0;
  logic [6:0] conv_bin;
  logic       conv_ready;
  logic       conv_done_tick;

  modport slave (
    input  req_a, req_b, bcd1_a, bcd0_a, bcd1_b, bcd0_b,
    input  conv_bin, conv_ready, conv_done_tick,
    output ack_a, ack_b, done_a, done_b, err_a, err_b, bin_out, busy,
    output conv_start, conv_bcd1, conv_bcd0
  );

  modport master (
    output req_a, req_b, bcd1_a, bcd0_a, bcd1_b, bcd0_b,
    output conv_bin, conv_ready, conv_done_tick,
    input  ack_a, ack_b, done_a, done_b, err_a, err_b, bin_out, busy,
    input  conv_start, conv_bcd1, conv_bcd0
  );
endinterface

// File: rtl/bcd2bin_arbiter.sv
// Round-robin arbiter sequencing two BCD clients onto one shared bcd2bin converter,
// with digit validation and a watchdog on the conversion.
module bcd2bin_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input logic               clk,
  input logic               reset,
  bcd2bin_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle, StIssue, StWait, StDeliver, StReject, StToerr
  } state_e;

  state_e     state_q, state_d;
  logic       gnt_q, gnt_d;
  logic       last_gnt_q, last_gnt_d;
  logic [3:0] bcd1_q, bcd1_d;
  logic [3:0] bcd0_q, bcd0_d;
  logic [6:0] bin_q, bin_d;
  logic [7:0] wcnt_q, wcnt_d;

  logic       win;
  logic [3:0] win_bcd1;
  logic [3:0] win_bcd0;

  // Contention goes to whoever was not served last.
  always_comb begin
    win      = (bus.req_a && bus.req_b) ? ~last_gnt_q : bus.req_b;
    win_bcd1 = win ? bus.bcd1_b : bus.bcd1_a;
    win_bcd0 = win ? bus.bcd0_b : bus.bcd0_a;
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    bcd1_d     = bcd1_q;
    bcd0_d     = bcd0_q;
    bin_d      = bin_q;
    wcnt_d     = wcnt_q;
    unique case (state_q)
      StIdle: begin
        if ((bus.req_a || bus.req_b) && bus.conv_ready) begin
          gnt_d   = win;
          bcd1_d  = win_bcd1;
          bcd0_d  = win_bcd0;
          state_d = (win_bcd1 > 4'd9 || win_bcd0 > 4'd9) ? StReject : StIssue;
        end
      end
      StIssue: begin
        wcnt_d  = 8'd0;
        state_d = StWait;
      end
      StWait: begin
        if (bus.conv_done_tick) begin
          bin_d   = bus.conv_bin;
          state_d = StDeliver;
        end else if (wcnt_q == 8'(TIMEOUT - 1)) begin
          state_d = StToerr;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      StDeliver, StReject, StToerr: begin
        last_gnt_d = gnt_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      bcd1_q     <= 4'd0;
      bcd0_q     <= 4'd0;
      bin_q      <= 7'd0;
      wcnt_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      bcd1_q     <= bcd1_d;
      bcd0_q     <= bcd0_d;
      bin_q      <= bin_d;
      wcnt_q     <= wcnt_d;
    end
  end

  // Handshake pulses are decoded from registered state only.
  logic ack_any;
  logic err_any;
  always_comb begin
    ack_any        = (state_q == StIssue) || (state_q == StReject);
    err_any        = (state_q == StReject) || (state_q == StToerr);
    bus.ack_a      = ack_any && !gnt_q;
    bus.ack_b      = ack_any && gnt_q;
    bus.err_a      = err_any && !gnt_q;
    bus.err_b      = err_any && gnt_q;
    bus.done_a     = (state_q == StDeliver) && !gnt_q;
    bus.done_b     = (state_q == StDeliver) && gnt_q;
    bus.conv_start = (state_q == StIssue);
    bus.busy       = (state_q != StIdle);
    bus.bin_out    = bin_q;
    bus.conv_bcd1  = bcd1_q;
    bus.conv_bcd0  = bcd0_q;
  end

endmodule

// File: tb/tb_bcd2bin_arbiter.sv
// Randomized self-checking bench for bcd2bin_arbiter with a latency-programmable converter
// model and a transaction-level reference for arbitration, results and timing.
module tb_bcd2bin_arbiter;
  localparam int T = 8;

  logic clk;
  logic reset;
  bcd2bin_arbiter_if bus ();

  bcd2bin_arbiter #(.TIMEOUT(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Converter model: done tick arrives `lat` cycles after the start cycle.
  int   lat;
  logic never, ready_en, force_tick;
  logic [4:0] cnt;
  always @(posedge clk) begin
    if (reset) cnt <= 5'd0;
    else if (bus.conv_start) cnt <= 5'(lat);
    else if (cnt != 5'd0) cnt <= cnt - 5'd1;
  end
  assign bus.conv_done_tick = ((cnt == 5'd1) && !never) || force_tick;
  assign bus.conv_ready     = (cnt == 5'd0) && ready_en;
  assign bus.conv_bin       = 7'(int'(bus.conv_bcd1) * 10 + int'(bus.conv_bcd0));

  int checks = 0, failures = 0;
  int mon_done = 0, mon_err = 0, mon_start = 0;
  int exp_done = 0, exp_err = 0, exp_start = 0;

  always @(negedge clk) begin
    if (!reset) begin
      mon_done  += int'(bus.done_a) + int'(bus.done_b);
      mon_err   += int'(bus.err_a) + int'(bus.err_b);
      mon_start += int'(bus.conv_start);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference state: pending requests, their digits, last winner and last delivered result.
  bit ra, rb;
  int a1, a0, b1, b0;
  int last_gnt_m = 1;
  int bin_m = 0;

  task automatic raise_a(input int d1, input int d0);
    a1 = d1; a0 = d0; ra = 1'b1;
    bus.bcd1_a = 4'(d1); bus.bcd0_a = 4'(d0); bus.req_a = 1'b1;
  endtask

  task automatic raise_b(input int d1, input int d0);
    b1 = d1; b0 = d0; rb = 1'b1;
    bus.bcd1_b = 4'(d1); bus.bcd0_b = 4'(d0); bus.req_b = 1'b1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ack"}, int'(bus.ack_a | bus.ack_b), 0);
    check({tag, "_done"}, int'(bus.done_a | bus.done_b), 0);
    check({tag, "_err"}, int'(bus.err_a | bus.err_b), 0);
    check({tag, "_start"}, int'(bus.conv_start), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_bin"}, int'(bus.bin_out), 0);
    check({tag, "_bcd"}, int'({bus.conv_bcd1, bus.conv_bcd0}), 0);
  endtask

  // Serve one arbitration round: predict the winner and its full outcome.
  task automatic serve(input int l, input int ack_limit);
    int  w, d1, d0, res;
    bit  got, invalid, timeout;
    w = (ra && rb) ? ((last_gnt_m == 1) ? 0 : 1) : (rb ? 1 : 0);
    d1 = w ? b1 : a1;
    d0 = w ? b0 : a0;
    invalid = (d1 > 9) || (d0 > 9);
    timeout = never || (l > T);
    lat = l;
    got = 1'b0;
    for (int k = 0; k < ack_limit && !got; k++) begin
      @(negedge clk);
      got = bus.ack_a | bus.ack_b;
    end
    check("ack_seen", int'(got), 1);
    if (!got) return;
    check("ack_a", int'(bus.ack_a), int'(w == 0));
    check("ack_b", int'(bus.ack_b), int'(w == 1));
    if (w == 1) begin bus.req_b = 1'b0; rb = 1'b0; end
    else begin bus.req_a = 1'b0; ra = 1'b0; end
    last_gnt_m = w;
    if (invalid) begin
      exp_err++;
      check("rej_err", int'(w ? bus.err_b : bus.err_a), 1);
      check("rej_nostart", int'(bus.conv_start), 0);
      check("rej_bin", int'(bus.bin_out), bin_m);
      @(negedge clk);
      check("rej_idle", int'(bus.busy), 0);
      return;
    end
    exp_start++;
    check("start", int'(bus.conv_start), 1);
    check("conv_bcd1", int'(bus.conv_bcd1), d1);
    check("conv_bcd0", int'(bus.conv_bcd0), d0);
    for (int c = 1; c <= (timeout ? T : l); c++) begin
      @(negedge clk);
      check("wait_busy", int'(bus.busy & ~(bus.done_a | bus.done_b | bus.err_a | bus.err_b)), 1);
    end
    @(negedge clk);
    if (timeout) begin
      exp_err++;
      check("to_err", int'(w ? bus.err_b : bus.err_a), 1);
      check("to_nodone", int'(bus.done_a | bus.done_b), 0);
      check("to_bin", int'(bus.bin_out), bin_m);
    end else begin
      exp_done++;
      res = d1 * 10 + d0;
      check("done", int'(w ? bus.done_b : bus.done_a), 1);
      check("bin_out", int'(bus.bin_out), res);
      bin_m = res;
    end
    @(negedge clk);
    check("back_idle", int'(bus.busy), 0);
  endtask

  task automatic pulse_stray(input string tag);
    force_tick = 1'b1;
    @(negedge clk);
    force_tick = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check(tag, int'(bus.done_a | bus.done_b), 0);
      @(negedge clk);
    end
  endtask

  initial begin
    int  d1, d0;
    bit  got;
    reset = 1'b1; ready_en = 1'b1; never = 1'b0; force_tick = 1'b0; lat = 3;
    ra = 1'b0; rb = 1'b0;
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    bus.bcd1_a = 4'd0; bus.bcd0_a = 4'd0; bus.bcd1_b = 4'd0; bus.bcd0_b = 4'd0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    reset = 1'b0;

    raise_a(9, 7);                 serve(4, 20);
    raise_a(4, 2); raise_b(1, 5);  serve(3, 20); serve(3, 20);
    raise_b(3, 0);                 serve(2, 20);
    raise_a(0, 8); raise_b(6, 6);  serve(2, 20); serve(2, 20);
    raise_b(1, 10);                serve(3, 20);

    never = 1'b1;
    raise_a(5, 5); serve(3, 20);
    pulse_stray("stray_after_to");
    never = 1'b0;

    raise_a(2, 3); serve(T, 20);   // tick coincides with last watchdog count

    ready_en = 1'b0;
    raise_a(7, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("busy_conv_noack", int'(bus.ack_a), 0);
    end
    ready_en = 1'b1;
    serve(3, 1);

    // Reset while a conversion is in WAIT.
    lat = 20;
    raise_a(3, 3);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = bus.ack_a;
    end
    check("rst_ack_seen", int'(got), 1);
    bus.req_a = 1'b0; ra = 1'b0;
    if (got) exp_start++;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_quiet("midreset");
    reset = 1'b0;
    last_gnt_m = 1; bin_m = 0;
    pulse_stray("stray_after_rst");
    raise_a(1, 2); serve(3, 20);

    for (int i = 0; i < 40; i++) begin
      if (!ra && ($urandom_range(0, 1) == 1 || !rb)) begin
        d1 = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
        d0 = $urandom_range(0, 9);
        raise_a(d1, d0);
      end
      if (!rb && $urandom_range(0, 1) == 1) begin
        d1 = $urandom_range(0, 9);
        d0 = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
        raise_b(d1, d0);
      end
      serve($urandom_range(1, 12), 60);
    end
    if (ra || rb) serve(2, 60);
    if (ra || rb) serve(2, 60);
    repeat (15) @(negedge clk);

    check("count_done", mon_done, exp_done);
    check("count_err", mon_err, exp_err);
    check("count_start", mon_start, exp_start);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
